hit_judge: RTL and testbench



---
 rtl/hit_judge_if.sv | 27 ++
 rtl/hit_judge.sv | 149 ++++++++++++++
 tb/tb_hit_judge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_judge_if.sv
// Bundles the note, key and judgment signals shared between the sequencer side
// and the hit judge.
interface hit_judge_if #(
  parameter int LANES = 8
);
  logic             en;
  logic             tick;
  logic             note_valid;
  logic [LANES-1:0] note;
  logic [LANES-1:0] key;
  logic [LANES-1:0] lane_pending;
  logic             busy;
  logic             hit;
  logic             miss;
  logic [6:0]       score;
  logic [6:0]       combo;

  modport master (
    output en, tick, note_valid, note, key,
    input  lane_pending, busy, hit, miss, score, combo
  );

  modport slave (
    input  en, tick, note_valid, note, key,
    output lane_pending, busy, hit, miss, score, combo
  );
endinterface

// File: rtl/hit_judge.sv
// Rhythm-game judge: synchronises and debounces the lane keys, then judges each
// note within a tick-counted window and keeps saturating score/combo counters.
module hit_judge #(
  parameter int LANES     = 8,
  parameter int WIN       = 4,
  parameter int DEB_CYC   = 4,
  parameter int SCORE_MAX = 99
) (
  input logic       CLK,
  input logic       RESETN,
  hit_judge_if.slave bus
);
  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam int WIN_W = $clog2(WIN + 1);

  typedef enum logic {IDLE, OPEN} state_t;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    if (v >= 7'(SCORE_MAX)) return 7'(SCORE_MAX);
    return v + 7'd1;
  endfunction

  logic [LANES-1:0] key_p0, key_p1, deb_p2, deb_d, press_p3;
  logic [CNT_W-1:0] deb_cnt [LANES];

  // Stages p0/p1: synchroniser; p2: debounced level; p3: rising-edge press pulse
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      key_p0   <= '0;
      key_p1   <= '0;
      deb_p2   <= '0;
      deb_d    <= '0;
      press_p3 <= '0;
      for (int i = 0; i < LANES; i++) deb_cnt[i] <= '0;
    end else begin
      key_p0 <= bus.key;
      key_p1 <= key_p0;
      for (int i = 0; i < LANES; i++) begin
        if (key_p1[i] == deb_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEB_CYC)) begin
          deb_p2[i]  <= key_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
      deb_d    <= deb_p2;
      press_p3 <= deb_p2 & ~deb_d;
    end
  end

  state_t           state, state_n;
  logic [LANES-1:0] pend, pend_n;
  logic [WIN_W-1:0] win_cnt, win_n;
  logic             hit_r, hit_n, miss_r, miss_n, done;
  logic [6:0]       score_r, score_n, combo_r, combo_n;

  // Judgment stage: consumes press_p3, registers pulses and counters
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= IDLE;
      pend    <= '0;
      win_cnt <= '0;
      hit_r   <= 1'b0;
      miss_r  <= 1'b0;
      score_r <= '0;
      combo_r <= '0;
    end else begin
      state   <= state_n;
      pend    <= pend_n;
      win_cnt <= win_n;
      hit_r   <= hit_n;
      miss_r  <= miss_n;
      score_r <= score_n;
      combo_r <= combo_n;
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    win_n   = win_cnt;
    hit_n   = 1'b0;
    miss_n  = 1'b0;
    done    = 1'b0;
    score_n = score_r;
    combo_n = combo_r;
    if (!bus.en) begin
      state_n = IDLE;
      pend_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.note_valid && (bus.note != '0)) begin
            pend_n  = bus.note;
            win_n   = WIN_W'(WIN);
            state_n = OPEN;
          end
        end
        OPEN: begin
          if ((press_p3 & ~pend) != '0) begin
            miss_n = 1'b1;
            done   = 1'b1;
          end else if ((pend & ~press_p3) == '0) begin
            hit_n = 1'b1;
            done  = 1'b1;
          end else begin
            pend_n = pend & ~press_p3;
            // A new note arriving forces the current one to expire
            if (bus.note_valid || (bus.tick && (win_cnt == WIN_W'(1)))) begin
              miss_n = 1'b1;
              done   = 1'b1;
            end else if (bus.tick) begin
              win_n = win_cnt - WIN_W'(1);
            end
          end
          if (done) begin
            state_n = IDLE;
            pend_n  = '0;
          end
          if (bus.note_valid) begin
            if (bus.note != '0) begin
              pend_n  = bus.note;
              win_n   = WIN_W'(WIN);
              state_n = OPEN;
            end else begin
              pend_n  = '0;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (hit_n) begin
      score_n = sat_inc(score_r);
      combo_n = sat_inc(combo_r);
    end
    if (miss_n) combo_n = '0;
  end

  assign bus.lane_pending = pend;
  assign bus.busy         = (state == OPEN);
  assign bus.hit          = hit_r;
  assign bus.miss         = miss_r;
  assign bus.score        = score_r;
  assign bus.combo        = combo_r;
endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a behavioural model.
module tb_hit_judge;
  localparam int LANES = 8;
  localparam int WIN   = 4;
  localparam int DEB   = 4;
  localparam int SMAX  = 99;

  logic clk, rstn;
  hit_judge_if #(.LANES(LANES)) bus();

  hit_judge #(.LANES(LANES), .WIN(WIN), .DEB_CYC(DEB), .SCORE_MAX(SMAX)) dut (
    .CLK(clk), .RESETN(rstn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: window-based debounce, integer hit/run counts clipped to SMAX
  logic [7:0]  m_s0, m_s1, m_lvl, m_lvl_d, m_prs, m_pend;
  logic [7:0]  m_hist [0:DEB];
  bit          m_open, m_hit, m_miss;
  int          m_left;
  int unsigned m_hits, m_run;

  always @(posedge clk) begin
    logic [7:0] new_lvl;
    bit         done, all_diff;
    if (!rstn) begin
      m_s0 = '0; m_s1 = '0; m_lvl = '0; m_lvl_d = '0; m_prs = '0; m_pend = '0;
      for (int j = 0; j <= DEB; j++) m_hist[j] = '0;
      m_open = 0; m_hit = 0; m_miss = 0; m_left = 0; m_hits = 0; m_run = 0;
    end else begin
      m_hit = 0;
      m_miss = 0;
      if (!bus.en) begin
        m_open = 0;
        m_pend = '0;
      end else if (!m_open) begin
        if (bus.note_valid && bus.note != 0) begin
          m_open = 1; m_pend = bus.note; m_left = WIN;
        end
      end else begin
        done = 0;
        if ((m_prs & ~m_pend) != 0) begin
          m_miss = 1; done = 1;
        end else if ((m_pend & ~m_prs) == 0) begin
          m_hit = 1; done = 1;
        end else begin
          m_pend = m_pend & ~m_prs;
          if (bus.note_valid || (bus.tick && m_left == 1)) begin
            m_miss = 1; done = 1;
          end else if (bus.tick) begin
            m_left = m_left - 1;
          end
        end
        if (done) begin
          m_open = 0; m_pend = '0;
        end
        if (bus.note_valid) begin
          if (bus.note != 0) begin
            m_open = 1; m_pend = bus.note; m_left = WIN;
          end else begin
            m_open = 0; m_pend = '0;
          end
        end
      end
      if (m_hit) begin
        m_hits++;
        m_run++;
      end
      if (m_miss) m_run = 0;
      // Level flips once the last DEB+1 synchronised samples all disagree with it
      for (int j = DEB; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s1;
      new_lvl = m_lvl;
      for (int i = 0; i < LANES; i++) begin
        all_diff = 1;
        for (int j = 0; j <= DEB; j++) if (m_hist[j][i] == m_lvl[i]) all_diff = 0;
        if (all_diff) new_lvl[i] = ~m_lvl[i];
      end
      m_prs   = m_lvl & ~m_lvl_d;
      m_lvl_d = m_lvl;
      m_lvl   = new_lvl;
      m_s1    = m_s0;
      m_s0    = bus.key;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("pending", 32'(bus.lane_pending), 32'(m_pend));
      cmp("busy",    32'(bus.busy),  32'(m_open));
      cmp("hit",     32'(bus.hit),   32'(m_hit));
      cmp("miss",    32'(bus.miss),  32'(m_miss));
      cmp("score",   32'(bus.score), (m_hits > SMAX) ? SMAX : m_hits);
      cmp("combo",   32'(bus.combo), (m_run > SMAX) ? SMAX : m_run);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_note(input logic [7:0] v);
    bus.note_valid = 1'b1;
    bus.note = v;
    cyc(1);
    bus.note_valid = 1'b0;
    bus.note = '0;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  task automatic do_hit();
    logic [7:0] m;
    m = 8'($urandom_range(1, 255));
    send_note(m);
    bus.key = m;
    cyc(9);
    bus.key = '0;
    cyc(8);
  endtask

  initial begin
    int hits_seen;
    rstn = 1'b0;
    bus.en = 1'b0; bus.tick = 1'b0; bus.note_valid = 1'b0; bus.note = '0; bus.key = '0;
    cyc(3);
    chk_on = 1;
    cmp("rst_score", 32'(bus.score), 0);
    cmp("rst_busy",  32'(bus.busy), 0);
    cmp("rst_pend",  32'(bus.lane_pending), 0);
    rstn = 1'b1;
    bus.en = 1'b1;
    cyc(1);

    // Single-lane hit: hit lands 8 edges after the key is first sampled
    send_note(8'h01);
    cmp("t1_pend", 32'(bus.lane_pending), 32'h01);
    bus.key = 8'h01;
    cyc(8);
    cmp("t1_early", 32'(bus.hit), 0);
    cyc(1);
    cmp("t1_hit",   32'(bus.hit), 1);
    cmp("t1_score", 32'(bus.score), 1);
    cmp("t1_combo", 32'(bus.combo), 1);
    cmp("t1_busy",  32'(bus.busy), 0);
    cyc(1);
    bus.key = '0;
    cyc(10);

    // Chord 0x81: partial then complete
    send_note(8'h81);
    cmp("t2_pend0", 32'(bus.lane_pending), 32'h81);
    bus.key = 8'h01;
    cyc(9);
    cmp("t2_pend1", 32'(bus.lane_pending), 32'h80);
    bus.key = '0;
    pulse_tick();
    pulse_tick();
    bus.key = 8'h80;
    cyc(9);
    cmp("t2_hit",   32'(bus.hit), 1);
    cmp("t2_pend2", 32'(bus.lane_pending), 0);
    cmp("t2_score", 32'(bus.score), 2);
    bus.key = '0;
    cyc(10);

    // Expiry on the 4th tick, then a wrong press
    send_note(8'h04);
    repeat (4) pulse_tick();
    cmp("t3_miss",  32'(bus.miss), 1);
    cmp("t3_combo", 32'(bus.combo), 0);
    send_note(8'h02);
    bus.key = 8'h08;
    cyc(9);
    cmp("t3_wrong", 32'(bus.miss), 1);
    cmp("t3_busy",  32'(bus.busy), 0);
    bus.key = '0;
    cyc(10);

    // Bounce rejection
    send_note(8'h01);
    for (int i = 0; i < 10; i++) begin
      bus.key[0] = ~bus.key[0];
      cyc(2);
    end
    bus.key = 8'h01;
    hits_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.hit) hits_seen++;
    end
    cmp("t4_hits",  32'(hits_seen), 1);
    cmp("t4_score", 32'(bus.score), 3);
    bus.key = '0;
    cyc(10);

    // Completion on the expiry tick
    send_note(8'h01);
    repeat (3) pulse_tick();
    bus.key = 8'h01;
    cyc(8);
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    cmp("b1_hit",  32'(bus.hit), 1);
    cmp("b1_miss", 32'(bus.miss), 0);
    bus.key = '0;
    cyc(10);

    // New note while 0x10 pending
    send_note(8'h10);
    cyc(2);
    send_note(8'h20);
    cmp("b2_miss", 32'(bus.miss), 1);
    cmp("b2_pend", 32'(bus.lane_pending), 32'h20);
    repeat (3) pulse_tick();
    cmp("b2_fresh", 32'(bus.busy), 1);

    // en dropped mid-note
    bus.en = 1'b0;
    cyc(1);
    cmp("b3_busy",  32'(bus.busy), 0);
    cmp("b3_miss",  32'(bus.miss), 0);
    cmp("b3_score", 32'(bus.score), 4);
    bus.en = 1'b1;

    // Reset mid-note
    send_note(8'h03);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    cmp("b4_busy",  32'(bus.busy), 0);
    cmp("b4_score", 32'(bus.score), 0);
    cmp("b4_pend",  32'(bus.lane_pending), 0);

    // Saturation
    repeat (105) do_hit();
    cmp("sat_score", 32'(bus.score), SMAX);
    cmp("sat_combo", 32'(bus.combo), SMAX);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rstn = ($urandom_range(0, 599) != 0);
      bus.en = ($urandom_range(0, 39) != 0);
      bus.tick = ($urandom_range(0, 2) == 0);
      bus.note_valid = ($urandom_range(0, 11) == 0);
      bus.note = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int i = 0; i < LANES; i++)
        if ($urandom_range(0, 11) == 0) bus.key[i] = ~bus.key[i];
      cyc(1);
    end
    rstn = 1'b1;
    bus.note_valid = 1'b0;
    bus.tick = 1'b0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
